// File: rtl/hid_uart_cmd_rx.sv
// 8N1 UART receiver plus ASCII hex line parser producing synthetic HID keyboard/mouse reports.
// Lines: "K" + 10 hex digits or "M" + 6 hex digits, terminated by CR or LF; spaces ignored.
module hid_uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [1:0] typ,
  output logic       report,
  output logic       err,
  output logic [7:0] key_modifiers,
  output logic [7:0] key1,
  output logic [7:0] key2,
  output logic [7:0] key3,
  output logic [7:0] key4,
  output logic [7:0] mouse_btn,
  output logic [7:0] mouse_dx,
  output logic [7:0] mouse_dy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DIGITS, P_SKIP} p_state_t;

  rx_state_t     rx_state;
  logic [1:0]    sync;
  logic          rx_in;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_valid;
  logic          frame_err;
  logic [7:0]    rx_byte;

  assign rx_in = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      rx_state  <= RX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      sync      <= {sync[0], uart_rx};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_in) begin
            bit_cnt  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_M1) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_in ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            shift   <= {rx_in, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so a minimal one-bit stop never costs the next start edge.
          if (bit_cnt == FULL_M1) begin
            bit_cnt   <= '0;
            rx_valid  <= rx_in;
            frame_err <= ~rx_in;
            rx_byte   <= shift;
            rx_state  <= RX_IDLE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic       is_dec, is_alpha, is_hex, is_term, is_space;
  logic [3:0] nib;

  // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15.
  always_comb begin
    is_dec   = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    is_alpha = ((rx_byte >= 8'h41) && (rx_byte <= 8'h46)) ||
               ((rx_byte >= 8'h61) && (rx_byte <= 8'h66));
    is_hex   = is_dec || is_alpha;
    is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    is_space = (rx_byte == 8'h20);
    nib      = rx_byte[3:0] + (is_alpha ? 4'd9 : 4'd0);
  end

  p_state_t    p_state;
  logic        kbd;
  logic [39:0] sr;
  logic [3:0]  dcnt;
  logic [3:0]  need;

  assign need = kbd ? 4'd10 : 4'd6;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state       <= P_IDLE;
      kbd           <= 1'b0;
      sr            <= '0;
      dcnt          <= '0;
      typ           <= 2'd0;
      report        <= 1'b0;
      err           <= 1'b0;
      key_modifiers <= '0;
      key1          <= '0;
      key2          <= '0;
      key3          <= '0;
      key4          <= '0;
      mouse_btn     <= '0;
      mouse_dx      <= '0;
      mouse_dy      <= '0;
    end else begin
      report <= 1'b0;
      err    <= 1'b0;
      if (frame_err) begin
        err     <= 1'b1;
        p_state <= P_SKIP;
      end else if (rx_valid) begin
        case (p_state)
          P_IDLE: begin
            if (rx_byte == 8'h4B || rx_byte == 8'h6B || rx_byte == 8'h4D || rx_byte == 8'h6D) begin
              kbd     <= (rx_byte == 8'h4B) || (rx_byte == 8'h6B);
              sr      <= '0;
              dcnt    <= '0;
              p_state <= P_DIGITS;
            end else if (!(is_term || is_space)) begin
              err     <= 1'b1;
              p_state <= P_SKIP;
            end
          end
          P_DIGITS: begin
            if (is_hex) begin
              if (dcnt == need) begin
                err     <= 1'b1;
                p_state <= P_SKIP;
              end else begin
                sr   <= {sr[35:0], nib};
                dcnt <= dcnt + 4'd1;
              end
            end else if (is_term) begin
              p_state <= P_IDLE;
              if (dcnt != need) begin
                err <= 1'b1;
              end else if (kbd) begin
                report        <= 1'b1;
                typ           <= 2'd1;
                key_modifiers <= sr[39:32];
                key1          <= sr[31:24];
                key2          <= sr[23:16];
                key3          <= sr[15:8];
                key4          <= sr[7:0];
              end else begin
                report    <= 1'b1;
                typ       <= 2'd2;
                mouse_btn <= sr[23:16];
                mouse_dx  <= sr[15:8];
                mouse_dy  <= sr[7:0];
              end
            end else if (!is_space) begin
              err     <= 1'b1;
              p_state <= P_SKIP;
            end
          end
          P_SKIP: begin
            if (is_term) p_state <= P_IDLE;
          end
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

endmodule
